// File: rtl/tp_event_merger.sv
// Event merger: per-channel FIFOs feeding one output stream, one complete event at a time.
module tp_event_merger #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned W     = 65,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH*W-1:0] din,
    input  logic [NCH-1:0]   din_valid,
    output logic [NCH-1:0]   din_ready,
    output logic [W-1:0]     dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [31:0]      evt_count
);
    localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned OW = AW + 1;

    typedef enum logic {
        ARB    = 1'b0,
        STREAM = 1'b1
    } state_e;

    // Per-channel FIFO storage and bookkeeping
    logic [W-1:0]   mem_q    [NCH][DEPTH];
    logic [AW-1:0]  wr_ptr_q [NCH];
    logic [AW-1:0]  rd_ptr_q [NCH];
    logic [OW-1:0]  cnt_q    [NCH];
    logic [OW-1:0]  cnt_d    [NCH];
    logic [NCH-1:0] din_ready_q;
    logic [NCH-1:0] nonempty_q;
    logic [NCH-1:0] wr_en;
    logic [NCH-1:0] rd_en;
    logic [NCH-1:0] avail;

    // Arbitration / streaming control; grant_q doubles as last_grant while in ARB
    state_e        state_q;
    state_e        state_d;
    logic [CW-1:0] grant_q;
    logic [CW-1:0] grant_d;
    logic [CW-1:0] arb_idx;
    logic          arb_found;

    logic [W-1:0]  rd_data;
    logic          rd_nonempty;
    logic          rd_eoe;
    logic          load;

    // Output register and event counter
    logic [W-1:0]  dout_q;
    logic          dout_valid_q;
    logic [31:0]   evt_count_q;

    assign din_ready  = din_ready_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign evt_count  = evt_count_q;

    // Head of the granted FIFO and the output-register load decision
    always_comb begin
        rd_data     = mem_q[grant_q][rd_ptr_q[grant_q]];
        rd_nonempty = (cnt_q[grant_q] != '0);
        rd_eoe      = rd_data[W-1] & rd_data[W-2];
        load        = (state_q == STREAM) && rd_nonempty && (!dout_valid_q || dout_ready);
    end

    // Per-channel push/pop strobes, next occupancy and arbitration eligibility
    always_comb begin
        wr_en = '0;
        rd_en = '0;
        avail = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            cnt_d[i] = cnt_q[i];
            wr_en[i] = din_valid[i] & din_ready_q[i];
            rd_en[i] = load && (grant_q == CW'(i));
            cnt_d[i] = cnt_q[i] + OW'(wr_en[i]) - OW'(rd_en[i]);
            // A channel becomes eligible only after its word has sat in the FIFO for a cycle
            avail[i] = nonempty_q[i] && (cnt_q[i] != '0);
        end
    end

    // Next-state logic: round-robin search in ARB, hold grant until EOE leaves in STREAM
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        arb_idx   = '0;
        arb_found = 1'b0;
        case (state_q)
            ARB: begin
                for (int unsigned k = 1; k <= NCH; k++) begin
                    arb_idx = CW'((32'(grant_q) + k) % NCH);
                    if (!arb_found && avail[arb_idx]) begin
                        arb_found = 1'b1;
                        grant_d   = arb_idx;
                    end
                end
                if (arb_found) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (load && rd_eoe) begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    // FSM state and grant registers; reset makes channel 0 the first candidate
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB;
            grant_q <= CW'(NCH - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    // FIFO storage writes; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NCH; i++) begin
            if (wr_en[i]) begin
                mem_q[i][wr_ptr_q[i]] <= din[i*W +: W];
            end
        end
    end

    // FIFO pointers, occupancy and registered ready/not-empty flags
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            din_ready_q <= '0;
            nonempty_q  <= '0;
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (wr_en[i]) begin
                    wr_ptr_q[i] <= wr_ptr_q[i] + AW'(1);
                end
                if (rd_en[i]) begin
                    rd_ptr_q[i] <= rd_ptr_q[i] + AW'(1);
                end
                cnt_q[i]       <= cnt_d[i];
                din_ready_q[i] <= (cnt_d[i] < OW'(DEPTH));
                nonempty_q[i]  <= (cnt_q[i] != '0);
            end
        end
    end

    // Output register: refill on load, otherwise drain on downstream accept
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else if (load) begin
            dout_q       <= rd_data;
            dout_valid_q <= 1'b1;
        end else if (dout_ready) begin
            dout_valid_q <= 1'b0;
        end
    end

    // Count EOE words accepted downstream; wraps naturally at 32 bits
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_count_q <= '0;
        end else if (dout_valid_q && dout_ready && dout_q[W-1] && dout_q[W-2]) begin
            evt_count_q <= evt_count_q + 32'd1;
        end
    end

endmodule

// File: doc/tp_event_merger.md
TP_EVENT_MERGER -- requirements
Module: tp_event_merger

Interface
REQ-001 Parameter NCH, default 4, number of input channels (2..16).
REQ-002 Parameter W, default 65, word width including metadata flag at bit W-1.
REQ-003 Parameter DEPTH, default 16, per-channel FIFO depth in words (power of 2, >=4).
REQ-004 clk  input  1  single system clock, all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 din  input  NCH*W  channel i word at din[i*W +: W].
REQ-007 din_valid  input  NCH  per-channel word valid.
REQ-008 din_ready  output  NCH  per-channel FIFO can accept.
REQ-009 dout  output  W  merged output word.
REQ-010 dout_valid  output  1  dout holds a valid word.
REQ-011 dout_ready  input  1  downstream accepts dout.
REQ-012 evt_count  output  32  count of complete events forwarded.

Function
REQ-013 Word with bit W-1 = 1 SHALL be metadata; metadata word with bit W-2 = 1 SHALL be end-of-event (EOE) word; all other words pass as data.
REQ-014 Input handshake on channel i SHALL occur when din_valid[i] and din_ready[i] are both 1 at a rising edge; word written to FIFO i.
REQ-015 din_ready[i] SHALL be 1 iff FIFO i occupancy < DEPTH; registered, no combinational path from din_valid or dout_ready.
REQ-016 Full FIFO SHALL take no write; simultaneous read and write on a non-full FIFO SHALL leave occupancy unchanged.
REQ-017 FSM SHALL have two states: ARB and STREAM.
REQ-018 ARB: search channels round-robin from (last_grant+1) mod NCH; first channel with non-empty FIFO is granted and FSM enters STREAM next cycle; no non-empty FIFO keeps ARB.
REQ-019 STREAM: words from granted FIFO only, in order, into output register whenever output register empty or dout_ready = 1.
REQ-020 Transfer of an EOE word into output register SHALL return FSM to ARB and set last_grant to granted channel.
REQ-021 Events SHALL never interleave on dout; other channels wait while STREAM holds grant, even when granted FIFO is empty.
REQ-022 Output handshake when dout_valid and dout_ready both 1; dout and dout_valid SHALL stay stable while dout_valid = 1 and dout_ready = 0.
REQ-023 Minimum latency from input handshake (edge n) to dout_valid = 1 SHALL be 3 cycles (edge n+3) with empty merger and dout_ready = 1.
REQ-024 Sustained throughput in STREAM SHALL be one word per cycle with dout_ready held 1 and data available.
REQ-025 ARB cycle SHALL cost one bubble per event boundary; no further bubbles.
REQ-026 evt_count SHALL increment by 1 on each output handshake of an EOE word; wraps 0xFFFFFFFF -> 0.
REQ-027 Single-word event (lone EOE word) SHALL be legal and forwarded as a complete event.

Reset
REQ-028 rst = 1 at an edge SHALL empty all FIFOs, set FSM to ARB, last_grant to NCH-1 (channel 0 first), evt_count to 0.
REQ-029 Outputs after reset edge: dout_valid = 0, dout = 0, din_ready all 1 on cycle after rst deasserts; din_ready = 0 while rst = 1.
REQ-030 Reset mid-event SHALL discard partial event silently; no EOE synthesised; no input accepted while rst = 1.

Verification
REQ-031 Single channel: ch0 sends 3 data + EOE, dout_ready = 1 -> same 4 words on dout from edge n+3 consecutively, evt_count = 1.
REQ-032 Round-robin: ch0..ch3 each preloaded with one 2-word event -> dout order ch0,ch1,ch2,ch3, one bubble between events, evt_count = 4.
REQ-033 Backpressure: dout_ready = 0 for 20 cycles during ch1 stream -> dout held stable, FIFO1 fills to 16, din_ready[1] = 0, no word lost or duplicated after release.
REQ-034 No interleave: ch2 event stalls mid-event (FIFO2 empty) while ch3 has a full event -> ch3 words appear only after ch2 EOE forwarded.
REQ-035 Reset mid-event: rst pulsed after 2 of 5 words of ch0 on dout -> dout_valid = 0 next cycle, evt_count = 0, next ch1 event forwarded intact.
REQ-036 Wrap: evt_count forced to 0xFFFFFFFF via preload/long run, one more EOE -> evt_count = 0.
